// File: rtl/image_frame_loader.sv
// Purpose: captures a streamed 28x28 pixel frame into a local buffer and hands it to the inference core.
// Latency: nn_start pulses one cycle after the final pixel is accepted; rd_data is combinational from rd_addr.
// Backpressure: s_ready is registered; it drops after the final pixel and rises again the cycle after nn_done.
// Optional build macro: IMAGE_FRAME_LOADER_BINARIZE_EN stores (1 << SCALE_SHIFT) for pixels >= THRESH, else 0.
module image_frame_loader #(
    parameter int NUM_PIXELS  = 784,
    parameter int PIX_W       = 8,
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 16,
    parameter int SCALE_SHIFT = 0,
    parameter int THRESH      = 128
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              s_valid,
    input  logic [PIX_W-1:0]  s_data,
    input  logic              s_last,
    output logic              s_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              nn_start,
    input  logic              nn_done,
    output logic              busy,
    output logic              frame_err,
    output logic [9:0]        pixel_count,
    output logic [7:0]        frames_done
);

    localparam int                IDX_W    = $clog2(NUM_PIXELS);
    localparam logic [9:0]        LAST_IDX = 10'(NUM_PIXELS - 1);
    localparam logic [ADDR_W-1:0] RD_LIMIT = ADDR_W'(NUM_PIXELS);

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t state;

    // Frame storage; never cleared so a reset leaves the last frame readable.
    logic [DATA_W-1:0] frame_buf [NUM_PIXELS];

    logic              accept;
    logic              at_last;
    logic [DATA_W-1:0] store_word;

    // s_ready is only ever high in LOAD, so this is the LOAD-state acceptance.
    assign accept  = s_valid & s_ready;
    assign at_last = (pixel_count == LAST_IDX);

`ifdef IMAGE_FRAME_LOADER_BINARIZE_EN
    localparam logic [PIX_W:0] THRESH_V = (PIX_W + 1)'(THRESH);

    // Binarized word: a single scaled "one" for bright pixels, zero otherwise.
    always_comb begin
        store_word = '0;
        if ({1'b0, s_data} >= THRESH_V) begin
            store_word = DATA_W'(1) << SCALE_SHIFT;
        end
    end
`else
    // Plain word: pixel zero-extended then scaled, so the result is never negative.
    always_comb begin
        store_word = DATA_W'(s_data) << SCALE_SHIFT;
    end
`endif

    // Buffer write port: every accepted pixel lands at the current pixel index.
    always_ff @(posedge clk) begin
        if (accept) begin
            frame_buf[pixel_count[IDX_W-1:0]] <= store_word;
        end
    end

    // Combinational read; a same-cycle write is not visible until the next cycle.
    always_comb begin
        rd_data = '0;
        if (rd_addr < RD_LIMIT) begin
            rd_data = frame_buf[rd_addr[IDX_W-1:0]];
        end
    end

    // Control FSM with registered handshake, status and pulse outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= ST_LOAD;
            s_ready     <= 1'b1;
            nn_start    <= 1'b0;
            busy        <= 1'b0;
            frame_err   <= 1'b0;
            pixel_count <= '0;
            frames_done <= '0;
        end else begin
            nn_start  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                ST_LOAD: begin
                    if (accept) begin
                        if (at_last) begin
                            // Full frame: launch it even if the end marker is missing.
                            frame_err   <= ~s_last;
                            nn_start    <= 1'b1;
                            busy        <= 1'b1;
                            s_ready     <= 1'b0;
                            pixel_count <= '0;
                            state       <= ST_START;
                        end else if (s_last) begin
                            // Short frame: flag it and start over; stored words are simply overwritten later.
                            frame_err   <= 1'b1;
                            pixel_count <= '0;
                        end else begin
                            pixel_count <= pixel_count + 10'd1;
                        end
                    end
                end
                ST_START: begin
                    pixel_count <= '0;
                    state       <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (nn_done) begin
                        frames_done <= frames_done + 8'd1;
                        busy        <= 1'b0;
                        s_ready     <= 1'b1;
                        state       <= ST_LOAD;
                    end
                end
                default: begin
                    state   <= ST_LOAD;
                    s_ready <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_image_frame_loader.sv
// Purpose: self-checking bench for image_frame_loader using a scoreboard of expected buffer words.
// Latency: checks nn_start one cycle after the final pixel and re-acceptance one cycle after nn_done.
// Backpressure: holds s_valid high while the loader is busy and checks that s_ready stays low.
module tb_image_frame_loader;

`ifdef IMAGE_FRAME_LOADER_BINARIZE_EN
    localparam int SHIFT = 8;
`else
    localparam int SHIFT = 0;
`endif
    localparam int NPIX = 784;

    logic        clk = 1'b0;
    logic        resetn;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_last;
    logic        s_ready;
    logic [15:0] rd_addr;
    logic [31:0] rd_data;
    logic        nn_start;
    logic        nn_done;
    logic        busy;
    logic        frame_err;
    logic [9:0]  pixel_count;
    logic [7:0]  frames_done;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int err_cnt = 0;

    logic [31:0] sb_q [$];
    logic [31:0] last_frame [NPIX];

    image_frame_loader #(
        .NUM_PIXELS (NPIX),
        .PIX_W      (8),
        .DATA_W     (32),
        .ADDR_W     (16),
        .SCALE_SHIFT(SHIFT),
        .THRESH     (128)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .nn_start   (nn_start),
        .nn_done    (nn_done),
        .busy       (busy),
        .frame_err  (frame_err),
        .pixel_count(pixel_count),
        .frames_done(frames_done)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled away from the active edge.
    always @(negedge clk) begin
        if (nn_start === 1'b1) start_cnt++;
        if (frame_err === 1'b1) err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int p);
`ifdef IMAGE_FRAME_LOADER_BINARIZE_EN
        return (p >= 128) ? (32'd1 << SHIFT) : 32'd0;
`else
        return 32'(p) << SHIFT;
`endif
    endfunction

    function automatic int pix(input int pat, input int i);
        case (pat)
            0:       return i % 256;
            1:       return (i * 7 + 3) % 256;
            default: return 255 - (i % 256);
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one pixel and wait (bounded) until it is accepted.
    task automatic send_pixel(input int d, input logic last);
        int n = 0;
        s_valid = 1'b1;
        s_data  = 8'(d);
        s_last  = last;
        while (s_ready !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        if (s_ready !== 1'b1) chk("accept_timeout", 32'(s_ready), 32'd1);
        step();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input int pat, input int first, input int npix, input logic final_last);
        for (int i = first; i < npix; i++) begin
            sb_q.push_back(exp_word(pix(pat, i)));
            send_pixel(pix(pat, i), (i == npix - 1) ? final_last : 1'b0);
        end
    endtask

    // Read the whole buffer back and compare against the scoreboard.
    task automatic verify_frame();
        logic [31:0] e;
        for (int a = 0; a < NPIX; a++) begin
            rd_addr = 16'(a);
            #1;
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 32'(sb_q.size()), 32'd1);
                e = 32'd0;
            end else begin
                e = sb_q.pop_front();
            end
            last_frame[a] = e;
            if (rd_data !== e) chk("rd_frame", rd_data, e);
            else checks++;
        end
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        resetn  = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'd0;
        s_last  = 1'b0;
        rd_addr = 16'd0;
        nn_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;

        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_nn_start", 32'(nn_start), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_pixel_count", 32'(pixel_count), 32'd0);
        chk("rst_frames_done", 32'(frames_done), 32'd0);

        // Frame A: ramp pattern, proper end marker.
        send_frame(0, 0, NPIX, 1'b1);
        chk("a_nn_start", 32'(nn_start), 32'd1);
        chk("a_frame_err", 32'(frame_err), 32'd0);
        chk("a_busy", 32'(busy), 32'd1);
        chk("a_s_ready", 32'(s_ready), 32'd0);
        step();
        chk("a_nn_start_pulse", 32'(nn_start), 32'd0);
        rd_addr = 16'd300; #1; chk("rd_300", rd_data, exp_word(44));
        rd_addr = 16'd800; #1; chk("rd_800", rd_data, 32'd0);
        rd_addr = 16'd127; #1; chk("rd_127", rd_data, exp_word(127));
        rd_addr = 16'd128; #1; chk("rd_128", rd_data, exp_word(128));
        rd_addr = 16'd255; #1; chk("rd_255", rd_data, exp_word(255));
        verify_frame();
        step();

        // Upstream keeps pushing while the core runs.
        s_valid = 1'b1;
        s_data  = 8'(pix(1, 0));
        s_last  = 1'b0;
        for (int c = 0; c < 50; c++) begin
            chk("wait_s_ready", 32'(s_ready), 32'd0);
            chk("wait_busy", 32'(busy), 32'd1);
            step();
        end
        nn_done = 1'b1;
        step();
        nn_done = 1'b0;
        chk("done_frames_done", 32'(frames_done), 32'd1);
        chk("done_s_ready", 32'(s_ready), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_pixel_count", 32'(pixel_count), 32'd0);
        step();
        s_valid = 1'b0;
        chk("held_pixel_accepted", 32'(pixel_count), 32'd1);

        // Short frame: end marker on pixel 99.
        send_frame(1, 1, 100, 1'b1);
        chk("short_frame_err", 32'(frame_err), 32'd1);
        chk("short_pixel_count", 32'(pixel_count), 32'd0);
        chk("short_nn_start", 32'(nn_start), 32'd0);
        chk("short_s_ready", 32'(s_ready), 32'd1);
        sb_q.delete();
        step();
        chk("short_err_pulse", 32'(frame_err), 32'd0);

        // Frame B: full frame, with a read-while-write on address 5.
        send_frame(2, 0, 5, 1'b0);
        rd_addr = 16'd5; #1;
        chk("rdw_old", rd_data, exp_word(pix(1, 5)));
        sb_q.push_back(exp_word(pix(2, 5)));
        send_pixel(pix(2, 5), 1'b0);
        chk("rdw_new", rd_data, exp_word(pix(2, 5)));
        send_frame(2, 6, NPIX, 1'b1);
        chk("b_nn_start", 32'(nn_start), 32'd1);
        chk("b_frame_err", 32'(frame_err), 32'd0);
        verify_frame();
        step();
        nn_done = 1'b1; step(); nn_done = 1'b0;
        chk("b_frames_done", 32'(frames_done), 32'd2);
        nn_done = 1'b1; step(); nn_done = 1'b0;
        chk("load_done_ignored", 32'(frames_done), 32'd2);

        // Frame C: end marker missing on the final pixel.
        send_frame(1, 0, NPIX, 1'b0);
        chk("c_frame_err", 32'(frame_err), 32'd1);
        chk("c_nn_start", 32'(nn_start), 32'd1);
        verify_frame();
        step();
        chk("c_busy", 32'(busy), 32'd1);

        // Reset during WAIT abandons the frame; buffer survives.
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        chk("wrst_busy", 32'(busy), 32'd0);
        chk("wrst_s_ready", 32'(s_ready), 32'd1);
        chk("wrst_frames_done", 32'(frames_done), 32'd0);
        chk("wrst_pixel_count", 32'(pixel_count), 32'd0);
        rd_addr = 16'd10; #1;
        chk("wrst_buf_kept", rd_data, last_frame[10]);
        nn_done = 1'b1; step(); nn_done = 1'b0;
        chk("wrst_done_ignored", 32'(frames_done), 32'd0);
        chk("wrst_busy_after", 32'(busy), 32'd0);
        chk("wrst_ready_after", 32'(s_ready), 32'd1);

        step();
        chk("start_pulses", 32'(start_cnt), 32'd3);
        chk("err_pulses", 32'(err_cnt), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/image_frame_loader.md
Name: image_frame_loader

Overview:
- Upstream feeder for the inference core.
- Accepts a streamed 28x28 pixel frame over a valid/ready handshake and stores it in a local frame buffer.
- Exposes the buffer as a combinational read port that replaces the core's constant image ROM.
- Pulses the core's start once a full frame is captured, then blocks new input until the core reports done.

Parameters:
NUM_PIXELS, 784, pixels per frame; also the buffer depth.
PIX_W, 8, width of an incoming pixel.
DATA_W, 32, width of a stored and read-out word (signed fixed-point, matches the core's input data).
ADDR_W, 16, width of the read address (matches the core's input address).
SCALE_SHIFT, 0, left shift applied to each pixel before storage.
THRESH, 128, binarization threshold (used only with BINARIZE_EN).

Ports:
clk  input  1  clock
resetn  input  1  reset; synchronous, active-low
s_valid  input  1  pixel valid
s_data  input  PIX_W  pixel value, unsigned
s_last  input  1  marks the final pixel of a frame
s_ready  output  1  loader can accept a pixel
rd_addr  input  ADDR_W  buffer read address (driven by the core)
rd_data  output  DATA_W  buffer word at rd_addr
nn_start  output  1  one-cycle start pulse to the core
nn_done  input  1  core done (one-cycle pulse)
busy  output  1  frame handed off; core running
frame_err  output  1  one-cycle pulse on a framing error
pixel_count  output  10  pixels accepted in the current frame
frames_done  output  8  completed inferences, wraps 255->0

Behaviour:
- Reset: synchronous, sampled on the clk rising edge when resetn=0.
  - State returns to LOAD.
  - pixel_count=0, frames_done=0, nn_start=0, frame_err=0, busy=0.
  - s_ready=1 from the first cycle after reset deasserts.
  - Buffer contents are not cleared.
  - Reset mid-inference abandons the frame; a later nn_done is ignored unless the loader is in WAIT.
- Handshake: a pixel is accepted on a cycle where s_valid=1 and s_ready=1. The upstream side must hold its data while s_valid=1 and s_ready=0.
- Stored word:
  - Default: the pixel is zero-extended to DATA_W, then shifted left by SCALE_SHIFT (always non-negative).
  - It is written to buffer[pixel_count]; pixel_count then increments.
- States:
  - LOAD: s_ready=1.
    - Accepted pixel with pixel_count < NUM_PIXELS-1 and s_last=0: store it and increment.
    - Accepted pixel with s_last=1 and pixel_count < NUM_PIXELS-1 (short frame): store it, pulse frame_err, reset pixel_count to 0, stay in LOAD. The frame is discarded.
    - Accepted pixel at pixel_count == NUM_PIXELS-1: store it, go to START. If s_last=0 (long-frame marker missing), pulse frame_err but still launch the frame. Extra upstream pixels stall, because s_ready drops.
  - START: one cycle. nn_start=1, s_ready=0, busy=1, pixel_count resets to 0. Next state is WAIT.
  - WAIT: s_ready=0, busy=1.
    - nn_done=1 sampled: frames_done increments (wrapping), then go to LOAD with s_ready=1 on the following cycle.
    - nn_done while in LOAD or START is ignored.
- Latency: nn_start asserts the cycle after the final pixel is accepted. The first pixel of the next frame can be accepted one cycle after nn_done.
- Read port:
  - rd_data is a combinational function of rd_addr and the buffer.
  - rd_addr >= NUM_PIXELS returns 0.
  - A read and write to the same address in the same cycle returns the old value.
  - Reads are legal in any state. The core reads only after nn_start, so contents are stable throughout WAIT.
- Outputs nn_start, frame_err, busy, s_ready and pixel_count are registered or derived directly from state; there are no combinational paths from s_valid to s_ready.

Optional Feature:
- Macro IMAGE_FRAME_LOADER_BINARIZE_EN.
- Defined: the stored word is (1 << SCALE_SHIFT) when s_data >= THRESH, else 0.
- Undefined: the stored word is the pixel scaled as above.
- THRESH is unused when the macro is undefined.

Test Plan:
- Stream 784 pixels with value (i mod 256), s_last on pixel 783, SCALE_SHIFT=0 -> exactly one nn_start pulse, the cycle after pixel 783 is accepted.
  - Also: rd_addr=300 -> rd_data=44; rd_addr=800 -> rd_data=0.
- After nn_start, drive s_valid=1 continuously and pulse nn_done 50 cycles later -> s_ready=0 and busy=1 for those cycles.
  - Also: frames_done 0->1; the next pixel is accepted 1 cycle after nn_done.
- Short frame with s_last on pixel 99 -> frame_err pulses once, pixel_count=0, no nn_start.
  - Then a full 784-pixel frame -> normal launch.
- Full frame with s_last=0 on pixel 783 -> frame_err and nn_start pulse on the same cycle; the frame is launched.
- Assert resetn=0 for 1 cycle during WAIT -> busy=0, s_ready=1, frames_done=0.
  - A subsequent nn_done pulse is ignored, with no frames_done change.
- With BINARIZE_EN, THRESH=128, SCALE_SHIFT=8: pixel 127 -> rd_data=0; pixel 128 -> rd_data=256; pixel 255 -> rd_data=256.
